// File: rtl/pc_sel_reg_pkg.sv
// ----------------------------------------------------------------------------
// pc_pkg
//   Shared constants and types for the next-PC select/register block.
//   PC_INC     : sequential fetch increment (one 32-bit instruction).
//   pc_state_e : redirect-buffering FSM states (RUN / PEND).
// ----------------------------------------------------------------------------
package pc_pkg;

    localparam int unsigned PC_INC = 4;

    typedef enum logic {
        ST_RUN  = 1'b0,   // PC follows the live select every unstalled cycle
        ST_PEND = 1'b1    // a redirect arrived during a stall and is buffered
    } pc_state_e;

endpackage : pc_pkg

// File: rtl/pc_sel_reg_if.sv
// ----------------------------------------------------------------------------
// pc_sel_reg_if
//   Bundles the select/control inputs and the registered outputs of
//   pc_sel_reg.
//   master : drives src_tgt, pcsrc, stall, flush_clr; observes pc, pend,
//            misalign (the fetch/control side).
//   slave  : the PC register block itself.
//   src_tgt   : (NSRC-1)*XLEN flattened redirect targets, slice k-1 = source k
//   pcsrc     : source select, 0 = sequential
//   stall     : hold the PC this cycle
//   flush_clr : drop any buffered redirect
//   pc        : registered program counter
//   pend      : registered "redirect buffered" flag
//   misalign  : registered "last loaded PC not word aligned" flag
// ----------------------------------------------------------------------------
interface pc_sel_reg_if #(
    parameter int XLEN = 32,
    parameter int NSRC = 4
);
    localparam int SELW = $clog2(NSRC);

    logic [(NSRC-1)*XLEN-1:0] src_tgt;
    logic [SELW-1:0]          pcsrc;
    logic                     stall;
    logic                     flush_clr;
    logic [XLEN-1:0]          pc;
    logic                     pend;
    logic                     misalign;

    modport master (
        output src_tgt, pcsrc, stall, flush_clr,
        input  pc, pend, misalign
    );

    modport slave (
        input  src_tgt, pcsrc, stall, flush_clr,
        output pc, pend, misalign
    );

endinterface : pc_sel_reg_if

// File: rtl/pc_src_mux.sv
// ----------------------------------------------------------------------------
// pc_src_mux
//   Purely combinational next-PC source selector.
//   pc_i       : current PC (used for the sequential pc+PC_INC candidate)
//   src_tgt_i  : flattened redirect targets, slice k-1 belongs to source k
//   pcsrc_i    : source select; 0 or any value >= NSRC selects sequential
//   next_pc_o  : selected next PC
//   redirect_o : 1 when a real redirect source (1..NSRC-1) is selected
// ----------------------------------------------------------------------------
module pc_src_mux
    import pc_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int NSRC = 4
) (
    input  logic [XLEN-1:0]          pc_i,
    input  logic [(NSRC-1)*XLEN-1:0] src_tgt_i,
    input  logic [$clog2(NSRC)-1:0]  pcsrc_i,
    output logic [XLEN-1:0]          next_pc_o,
    output logic                     redirect_o
);

    localparam int SELW = $clog2(NSRC);

    // Candidate table: entry 0 is sequential, entries 1..NSRC-1 are targets.
    logic [XLEN-1:0] cand [NSRC];

    // Carry out of the increment is dropped: PC wraps modulo 2^XLEN.
    assign cand[0] = pc_i + XLEN'(PC_INC);

    generate
        for (genvar gi = 1; gi < NSRC; gi++) begin : g_unpack
            assign cand[gi] = src_tgt_i[(gi-1)*XLEN +: XLEN];
        end
    endgenerate

    // Select values with no matching source (>= NSRC when NSRC is not a
    // power of two) fall through to the sequential default.
    always_comb begin
        next_pc_o  = cand[0];
        redirect_o = 1'b0;
        for (int k = 1; k < NSRC; k++) begin
            if (pcsrc_i == SELW'(k)) begin
                next_pc_o  = cand[k];
                redirect_o = 1'b1;
            end
        end
    end

endmodule : pc_src_mux

// File: rtl/pc_sel_reg.sv
// ----------------------------------------------------------------------------
// pc_sel_reg
//   Program-counter register with next-PC source selection and a one-entry
//   redirect buffer. A redirect that arrives while the PC is stalled is held
//   in a pending register and applied when the stall releases, unless it is
//   flushed or superseded by a newer redirect.
//   clk   : clock, all state updates on the rising edge
//   rst_n : asynchronous active-low reset
//   bus   : pc_sel_reg_if.slave (src_tgt, pcsrc, stall, flush_clr in;
//           pc, pend, misalign out -- all outputs come straight from flops)
// Parameters: XLEN (PC width), NSRC (sources, 2..16), RESET_PC.
// ----------------------------------------------------------------------------
module pc_sel_reg
    import pc_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter int              NSRC     = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic        clk,
    input  logic        rst_n,
    pc_sel_reg_if.slave bus
);

    pc_state_e       state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] ptgt_q, ptgt_d;     // buffered redirect target
    logic            pend_q;
    logic            mis_q, mis_d;

    logic [XLEN-1:0] live_pc;            // next PC from the live select
    logic            redirect;           // live select is a real redirect

    pc_src_mux #(
        .XLEN (XLEN),
        .NSRC (NSRC)
    ) u_src_mux (
        .pc_i       (pc_q),
        .src_tgt_i  (bus.src_tgt),
        .pcsrc_i    (bus.pcsrc),
        .next_pc_o  (live_pc),
        .redirect_o (redirect)
    );

    // Next-state / datapath logic.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ptgt_d  = ptgt_q;

        case (state_q)
            ST_RUN: begin
                if (!bus.stall) begin
                    pc_d = live_pc;
                end else if (redirect) begin
                    ptgt_d  = live_pc;
                    state_d = ST_PEND;
                end
            end

            ST_PEND: begin
                if (!bus.stall) begin
                    // A live redirect beats the buffered one; a flush means
                    // the buffered target is simply ignored.
                    if (redirect || bus.flush_clr) begin
                        pc_d = live_pc;
                    end else begin
                        pc_d = ptgt_q;
                    end
                    state_d = ST_RUN;
                end else if (redirect) begin
                    // Newest redirect wins, even alongside a flush.
                    ptgt_d = live_pc;
                end else if (bus.flush_clr) begin
                    state_d = ST_RUN;
                end
            end

            default: begin
                state_d = ST_RUN;
            end
        endcase

        // The alignment flag tracks only values actually loaded into the PC.
        mis_d = bus.stall ? mis_q : (pc_d[1:0] != 2'b00);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            pc_q    <= RESET_PC;
            ptgt_q  <= '0;
            pend_q  <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ptgt_q  <= ptgt_d;
            // Dedicated flop so the output is not a decode of the state.
            pend_q  <= (state_d == ST_PEND);
            mis_q   <= mis_d;
        end
    end

    assign bus.pc       = pc_q;
    assign bus.pend     = pend_q;
    assign bus.misalign = mis_q;

endmodule : pc_sel_reg

// File: tb/tb_pc_sel_reg.sv
// ----------------------------------------------------------------------------
// tb_pc_sel_reg
//   Scoreboard bench for pc_sel_reg (XLEN=32, NSRC=5, RESET_PC=0x100).
//   The driver applies one input set per cycle, predicts the post-edge
//   outputs from a behavioural model and queues them; the monitor pops one
//   expectation per rising edge and compares.
// ----------------------------------------------------------------------------
module tb_pc_sel_reg;

    localparam int          XLEN  = 32;
    localparam int          NSRC  = 5;
    localparam logic [31:0] RST_PC = 32'h100;

    typedef struct {
        logic [31:0] pc;
        logic        pend;
        logic        mis;
        string       tag;
    } exp_t;

    logic clk;
    logic rst_n;

    pc_sel_reg_if #(.XLEN(XLEN), .NSRC(NSRC)) bus ();

    pc_sel_reg #(
        .XLEN     (XLEN),
        .NSRC     (NSRC),
        .RESET_PC (RST_PC)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          txn    = 0;

    // Behavioural model: the PC, whether a redirect is waiting, its target,
    // and the alignment flag of the last loaded PC.
    logic [31:0] m_pc;
    bit          m_pend;
    logic [31:0] m_ptgt;
    bit          m_mis;
    logic [31:0] tgt [NSRC-1];

    task automatic check_now(input string tag, input logic [31:0] pc_e,
                             input logic pend_e, input logic mis_e);
        checks++;
        if (bus.pc !== pc_e || bus.pend !== pend_e || bus.misalign !== mis_e) begin
            errors++;
            $display("FAIL %s: got pc=%h pend=%b mis=%b, expected pc=%h pend=%b mis=%b",
                     tag, bus.pc, bus.pend, bus.misalign, pc_e, pend_e, mis_e);
        end else begin
            $display("chk %s: pc=%h pend=%b mis=%b", tag, bus.pc, bus.pend, bus.misalign);
        end
    endtask

    task automatic model_reset();
        m_pc   = RST_PC;
        m_pend = 1'b0;
        m_ptgt = '0;
        m_mis  = 1'b0;
    endtask

    // One clock of stimulus; called just after a falling edge.
    task automatic step(input logic st, input logic [2:0] sel, input logic fl,
                        input string tag);
        exp_t        e;
        int          s;
        logic [31:0] live;
        bus.stall     = st;
        bus.pcsrc     = sel;
        bus.flush_clr = fl;
        for (int k = 0; k < NSRC-1; k++) bus.src_tgt[k*32 +: 32] = tgt[k];

        s    = (int'(sel) >= NSRC) ? 0 : int'(sel);
        live = (s != 0) ? tgt[s-1] : m_pc + 32'd4;
        if (!st) begin
            // Released: a buffered redirect is used only if nothing newer
            // is presented and it was not flushed.
            m_pc   = (m_pend && !fl && s == 0) ? m_ptgt : live;
            m_mis  = (m_pc[1:0] != 2'b00);
            m_pend = 1'b0;
        end else if (s != 0) begin
            m_pend = 1'b1;
            m_ptgt = live;
        end else if (fl) begin
            m_pend = 1'b0;
        end

        e.pc = m_pc; e.pend = m_pend; e.mis = m_mis; e.tag = tag;
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    // Asynchronous reset pulse placed between edges; checked before any edge.
    task automatic async_reset(input string tag);
        exp_t e;
        bus.stall = 1'b1; bus.pcsrc = '0; bus.flush_clr = 1'b0;
        #2 rst_n = 1'b0;
        #1 check_now(tag, RST_PC, 1'b0, 1'b0);
        model_reset();
        e.pc = m_pc; e.pend = 1'b0; e.mis = 1'b0; e.tag = {tag, "_held"};
        exp_q.push_back(e);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor: one expectation per rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                txn++;
                checks++;
                if (bus.pc !== e.pc || bus.pend !== e.pend || bus.misalign !== e.mis) begin
                    errors++;
                    $display("FAIL txn %0d %s: got pc=%h pend=%b mis=%b, expected pc=%h pend=%b mis=%b",
                             txn, e.tag, bus.pc, bus.pend, bus.misalign, e.pc, e.pend, e.mis);
                end else begin
                    $display("txn %0d %s: pc=%h pend=%b mis=%b",
                             txn, e.tag, bus.pc, bus.pend, bus.misalign);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    // Driver.
    initial begin
        logic st, fl;
        logic [2:0] sel;
        rst_n = 1'b1;
        bus.stall = 1'b0; bus.pcsrc = '0; bus.flush_clr = 1'b0; bus.src_tgt = '0;
        for (int k = 0; k < NSRC-1; k++) tgt[k] = '0;
        model_reset();
        #1 rst_n = 1'b0;
        #1 check_now("reset_state", RST_PC, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Sequential fetch after reset release.
        step(0, 3'd0, 0, "seq_104");
        step(0, 3'd0, 0, "seq_108");
        step(0, 3'd0, 0, "seq_10c");

        // Stalled redirect buffered, then applied.
        tgt[0] = 32'h200; step(0, 3'd1, 0, "jump_200");
        tgt[1] = 32'h800; step(1, 3'd2, 0, "stall_redir_800");
        step(0, 3'd0, 0, "release_800");

        // Newest redirect wins.
        step(1, 3'd2, 0, "pend_800");
        tgt[2] = 32'h900; step(1, 3'd3, 0, "overwrite_900");
        step(0, 3'd0, 0, "release_900");

        // Flush drops the buffered target.
        step(1, 3'd2, 0, "pend_again");
        step(1, 3'd0, 1, "flush");
        step(0, 3'd0, 0, "after_flush_seq");

        // Flush with a concurrent stalled redirect keeps the new one.
        step(1, 3'd2, 0, "pend_800b");
        tgt[1] = 32'hA00; step(1, 3'd2, 1, "flush_with_redir");
        step(0, 3'd0, 0, "release_a00");

        // Wrap and misalignment.
        tgt[0] = 32'hFFFF_FFFC; step(0, 3'd1, 0, "jump_fffffffc");
        step(0, 3'd0, 0, "wrap_0");
        tgt[0] = 32'h1002; step(0, 3'd1, 0, "misalign_1002");
        step(1, 3'd0, 0, "stall_keeps_mis");
        step(0, 3'd0, 0, "seq_1006");

        // Out-of-range select behaves as sequential.
        step(0, 3'd5, 0, "sel5_seq");
        step(0, 3'd7, 0, "sel7_seq");

        // Reset in the middle of a pending redirect.
        tgt[3] = 32'h4000; step(1, 3'd4, 0, "pend_4000");
        async_reset("reset_mid_pend");
        step(0, 3'd0, 0, "post_reset_104");

        // Randomized traffic.
        for (int n = 0; n < 300; n++) begin
            for (int k = 0; k < NSRC-1; k++)
                tgt[k] = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
            st  = ($urandom_range(0, 99) < 45);
            sel = 3'($urandom_range(0, 7));
            fl  = ($urandom_range(0, 99) < 15);
            if ($urandom_range(0, 99) == 0) async_reset("rand_reset");
            else step(st, sel, fl, "rand");
        end

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_pc_sel_reg

// File: doc/pc_sel_reg.md
PC_SEL_REG -- requirements
Module: pc_sel_reg

Interface
REQ-001 Parameter XLEN, default 32, PC and target width in bits.
REQ-002 Parameter NSRC, default 4, number of next-PC sources; legal range 2..16.
REQ-003 Parameter RESET_PC, default 0, PC value loaded at reset.
REQ-004 Parameter SELW, default $clog2(NSRC), select width; derived, never overridden.
REQ-005 clk  in  1  single clock; all state updates on its rising edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 src_tgt  in  (NSRC-1)*XLEN  flattened redirect targets; slice k-1 is the target for source k.
REQ-008 pcsrc  in  SELW  source select: 0 = sequential (pc+4), k = src_tgt slice k-1.
REQ-009 stall  in  1  hold PC this cycle.
REQ-010 flush_clr  in  1  discard any pending redirect.
REQ-011 pc  out  XLEN  current registered PC.
REQ-012 pend  out  1  a redirect is buffered awaiting stall release.
REQ-013 misalign  out  1  registered flag: last loaded PC had pc[1:0] != 0.

Function
REQ-014 The block SHALL form next-PC as pc+4 (modulo 2^XLEN; the carry out is dropped) when pcsrc == 0, and as src_tgt slice pcsrc-1 otherwise.
REQ-015 The block SHALL treat pcsrc >= NSRC as pcsrc == 0.
REQ-016 FSM states SHALL be RUN and PEND; the encoding is private to the module.
REQ-017 RUN, stall=0: the PC SHALL load next-PC on the edge (latency 1 cycle, from select to pc).
REQ-018 RUN, stall=1, pcsrc == 0: the PC SHALL hold and the state SHALL stay RUN.
REQ-019 RUN, stall=1, pcsrc != 0: the PC SHALL hold, the selected target SHALL be captured in the pending register, and the state SHALL go to PEND.
REQ-020 PEND, stall=1, pcsrc != 0: the pending register SHALL be overwritten with the new target, so the newest redirect wins.
REQ-021 PEND, stall=1, pcsrc == 0: the pending register SHALL hold.
REQ-022 PEND, stall=0: the PC SHALL load the pending target if pcsrc == 0, or the live redirect target if pcsrc != 0; the state SHALL return to RUN.
REQ-023 flush_clr=1 in PEND SHALL return the state to RUN without loading the pending target; the PC follows REQ-017/REQ-018 for that cycle.
REQ-024 When flush_clr=1 and pcsrc != 0 occur together with stall=1, the live redirect SHALL be captured, and the state SHALL end in PEND.
REQ-025 pend SHALL equal (state == PEND), registered.
REQ-026 misalign SHALL update only when the PC loads, and SHALL equal bits [1:0] of the loaded value != 0.
REQ-027 All outputs SHALL be driven from flops; there SHALL be no combinational path from input to output.

Reset
REQ-028 On rst_n low, pc SHALL become RESET_PC, the state RUN, pend 0, the pending register 0, and misalign 0, asynchronously.
REQ-029 Deassertion of rst_n SHALL take effect at the next clk edge; the first edge after release performs a normal REQ-017 update.
REQ-030 Reset asserted while in PEND SHALL discard the buffered target.

Structure
REQ-031 The package pc_pkg SHALL hold the PC_INC constant (4) and the FSM state typedef.
REQ-032 The target selection SHALL be a sub-module pc_src_mux (parametrised XLEN/NSRC, purely combinational); the FSM and registers SHALL be in pc_sel_reg.
REQ-033 The datapath SHALL contain no latches, and no reset SHALL be generated inside the module.

Verification
REQ-034 Reset release with RESET_PC=0x100, pcsrc=0, stall=0 for 3 cycles -> pc sequence 0x104, 0x108, 0x10C.
REQ-035 pc=0x200, stall=1, pcsrc=2 with target 0x800 -> pc holds at 0x200 and pend=1; stall=0, pcsrc=0 -> pc=0x800 and pend=0.
REQ-036 In PEND (target 0x800), stall=1, pcsrc=3 with target 0x900, then release -> pc=0x900.
REQ-037 In PEND, flush_clr=1 with stall=1 -> pend=0 and pc holds; on release, pcsrc=0 -> pc = old pc+4.
REQ-038 pc=0xFFFFFFFC, pcsrc=0 -> pc=0x0 (wrap); pcsrc=1 with target 0x1002 -> misalign=1.
REQ-039 rst_n pulsed low mid-PEND, between clock edges -> pc=RESET_PC and pend=0 immediately, before the next edge.
